// File: rtl/zt_pkg.sv
// Shared types for the major-cycle sequencer: state and beat encodings plus the
// one-hot layout of the state word driven to the register file.
package zt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QZ,
    S_JZ,
    S_ZX,
    S_ZD,
    S_STD,
    S_KT,
    S_KTCZ
  } state_t;

  typedef enum logic [1:0] {
    T0,
    T1,
    T2,
    T3
  } beat_t;

  localparam int ZT_W    = 7;
  localparam int ZT_QZ   = 0;
  localparam int ZT_JZ   = 1;
  localparam int ZT_ZX   = 2;
  localparam int ZT_ZD   = 3;
  localparam int ZT_STD  = 4;
  localparam int ZT_KT   = 5;
  localparam int ZT_KTCZ = 6;

  // IDLE has no bit: the register file sees an all-zero state word.
  function automatic logic [ZT_W-1:0] zt_onehot(input state_t s);
    logic [ZT_W-1:0] v;
    v = '0;
    case (s)
      S_QZ:    v[ZT_QZ]   = 1'b1;
      S_JZ:    v[ZT_JZ]   = 1'b1;
      S_ZX:    v[ZT_ZX]   = 1'b1;
      S_ZD:    v[ZT_ZD]   = 1'b1;
      S_STD:   v[ZT_STD]  = 1'b1;
      S_KT:    v[ZT_KT]   = 1'b1;
      S_KTCZ:  v[ZT_KTCZ] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/zt_beat_timer.sv
// Beat sequencer T0..T3 inside a major cycle; T1 stretches until memory is ready.
// tmo is combinational and fires on the MEM_TMO-th consecutive not-ready clock of T1.
module zt_beat_timer
  import zt_pkg::*;
#(
  parameter int MEM_TMO = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       active,
  input  logic       mem_rdy,
  output logic [1:0] beat,
  output logic       tmo
);

  localparam int            CW   = $clog2(MEM_TMO + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TMO - 1);

  beat_t         beat_q;
  logic [CW-1:0] wait_cnt;

  assign tmo  = active && (beat_q == T1) && !mem_rdy && (wait_cnt == LAST);
  assign beat = beat_q;

  always_ff @(posedge clk) begin
    if (rst || !active) begin
      beat_q   <= T0;
      wait_cnt <= '0;
    end else begin
      case (beat_q)
        T0: begin
          beat_q   <= T1;
          wait_cnt <= '0;
        end
        T1: begin
          if (mem_rdy || tmo) begin
            // A timeout abandons the cycle, so the next active state starts at T0.
            beat_q   <= mem_rdy ? T2 : T0;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        T2:      beat_q <= T3;
        default: beat_q <= T0;
      endcase
    end
  end

endmodule

// File: rtl/zt_seq_ctrl.sv
// Major-cycle sequencer: walks fetch/indirect/execute/interrupt/data-channel/console
// cycles and emits one-clock register-file strobes; arbitration happens at T3 only.
module zt_seq_ctrl
  import zt_pkg::*;
#(
  parameter int MEM_TMO = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_ind,
  input  logic       i_mref,
  input  logic       i_int_req,
  input  logic       i_int_en,
  input  logic       i_dch_req,
  input  logic       i_kt_req,
  input  logic       i_kt_store,
  input  logic       i_mem_rdy,
  output logic [6:0] o_zt,
  output logic       o_yx,
  output logic       o_dryx,
  output logic       o_drzt,
  output logic       o_drjd,
  output logic       o_drjcx,
  output logic       o_drjz,
  output logic       o_drjsz,
  output logic       o_jsz_cxd,
  output logic       o_mx_cxd,
  output logic       o_1_jd,
  output logic       o_nc_jcx,
  output logic       o_dmkt_jcx,
  output logic       o_int_ack,
  output logic       o_err
);

  state_t     state;
  state_t     nxt_state;
  state_t     saved;
  state_t     nxt_saved;
  state_t     cand;
  logic [1:0] beat_raw;
  beat_t      beat;
  logic       tmo;
  logic       active;
  logic       boundary;
  logic       dryx;
  logic       yx_val;
  logic       int_ack;
  logic [6:0] zt_val;
  logic       run_q;
  logic       err_q;
  logic       t0;
  logic       t2;
  logic       t3;
  logic       live;

  assign active = (state != S_IDLE);
  assign beat   = beat_t'(beat_raw);
  assign t0     = active && (beat == T0);
  assign t2     = active && (beat == T2);
  assign t3     = active && (beat == T3);

  zt_beat_timer #(
    .MEM_TMO (MEM_TMO)
  ) u_timer (
    .clk     (i_clk),
    .rst     (i_rst),
    .active  (active),
    .mem_rdy (i_mem_rdy),
    .beat    (beat_raw),
    .tmo     (tmo)
  );

  always_comb begin
    nxt_state = state;
    nxt_saved = saved;
    cand      = S_IDLE;
    boundary  = 1'b0;
    dryx      = 1'b0;
    yx_val    = run_q;
    int_ack   = 1'b0;
    zt_val    = zt_onehot(state);

    if (state == S_IDLE) begin
      if (i_start) begin
        nxt_state = S_QZ;
        dryx      = 1'b1;
        yx_val    = 1'b1;
      end else if (i_kt_req) begin
        nxt_state = i_kt_store ? S_KTCZ : S_KT;
      end
    end else if (tmo) begin
      nxt_state = S_IDLE;
      dryx      = 1'b1;
      yx_val    = 1'b0;
    end else if (beat == T3) begin
      case (state)
        S_QZ: begin
          if (i_ind)       cand = S_JZ;
          else if (i_mref) cand = S_ZX;
          else             boundary = 1'b1;
        end
        S_JZ:    cand = i_ind ? S_JZ : S_ZX;
        S_ZX:    boundary = 1'b1;
        S_ZD: begin
          cand    = S_JZ;
          int_ack = 1'b1;
        end
        S_STD:   cand = saved;
        default: cand = S_IDLE;
      endcase

      if (boundary) begin
        if (i_stop) begin
          nxt_state = S_IDLE;
          dryx      = 1'b1;
          yx_val    = 1'b0;
        end else if (i_dch_req) begin
          // A boundary steal resumes with a fresh fetch.
          nxt_state = S_STD;
          nxt_saved = S_QZ;
        end else if (i_int_req && i_int_en) begin
          nxt_state = S_ZD;
        end else begin
          nxt_state = S_QZ;
        end
      end else if (((state == S_QZ) || (state == S_JZ)) && i_dch_req) begin
        nxt_state = S_STD;
        nxt_saved = cand;
      end else begin
        nxt_state = cand;
      end

      zt_val = zt_onehot(nxt_state);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      saved <= S_QZ;
      run_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= nxt_state;
      saved <= nxt_saved;
      if (dryx) run_q <= yx_val;
      if (tmo)  err_q <= 1'b1;
    end
  end

  // Everything leaving the block is squashed during a reset clock.
  assign live       = ~i_rst;
  assign o_zt       = live ? zt_val : '0;
  assign o_yx       = live & yx_val;
  assign o_dryx     = live & dryx;
  assign o_drzt     = live & t3;
  assign o_drjd     = live & t0;
  assign o_jsz_cxd  = live & t0 & (state == S_QZ);
  assign o_1_jd     = live & t0 & (state == S_ZD);
  assign o_mx_cxd   = live & t0 & (state != S_QZ) & (state != S_ZD);
  assign o_drjcx    = live & t2;
  assign o_nc_jcx   = live & t2 & (state != S_KTCZ);
  assign o_dmkt_jcx = live & t2 & (state == S_KTCZ);
  assign o_drjz     = live & t3 & (state == S_QZ);
  assign o_drjsz    = live & t3 & (state == S_QZ);
  assign o_int_ack  = live & int_ack;
  assign o_err      = live & err_q;

endmodule

// File: tb/tb_zt_seq_ctrl.sv
// Directed bench for zt_seq_ctrl: per-clock input/expected-output tables per scenario.
module tb_zt_seq_ctrl;

  localparam int TMO = 255;

  // Input vector bit layout for drive().
  localparam logic [9:0] ST   = 10'h200;
  localparam logic [9:0] SP   = 10'h100;
  localparam logic [9:0] IND  = 10'h080;
  localparam logic [9:0] MREF = 10'h040;
  localparam logic [9:0] IRQ  = 10'h020;
  localparam logic [9:0] IEN  = 10'h010;
  localparam logic [9:0] DCH  = 10'h008;
  localparam logic [9:0] KTR  = 10'h004;
  localparam logic [9:0] KTS  = 10'h002;
  localparam logic [9:0] RDY  = 10'h001;

  logic       i_clk = 1'b0;
  logic       i_rst, i_start, i_stop, i_ind, i_mref, i_int_req, i_int_en;
  logic       i_dch_req, i_kt_req, i_kt_store, i_mem_rdy;
  logic [6:0] o_zt;
  logic       o_yx, o_dryx, o_drzt, o_drjd, o_drjcx, o_drjz, o_drjsz;
  logic       o_jsz_cxd, o_mx_cxd, o_1_jd, o_nc_jcx, o_dmkt_jcx, o_int_ack, o_err;
  logic [12:0] obs;

  int checks = 0;
  int passed = 0;

  always #5 i_clk = ~i_clk;

  zt_seq_ctrl #(.MEM_TMO(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
    .i_ind(i_ind), .i_mref(i_mref), .i_int_req(i_int_req), .i_int_en(i_int_en),
    .i_dch_req(i_dch_req), .i_kt_req(i_kt_req), .i_kt_store(i_kt_store),
    .i_mem_rdy(i_mem_rdy), .o_zt(o_zt), .o_yx(o_yx), .o_dryx(o_dryx),
    .o_drzt(o_drzt), .o_drjd(o_drjd), .o_drjcx(o_drjcx), .o_drjz(o_drjz),
    .o_drjsz(o_drjsz), .o_jsz_cxd(o_jsz_cxd), .o_mx_cxd(o_mx_cxd), .o_1_jd(o_1_jd),
    .o_nc_jcx(o_nc_jcx), .o_dmkt_jcx(o_dmkt_jcx), .o_int_ack(o_int_ack), .o_err(o_err)
  );

  // {dryx, yx, drjd, jsz_cxd, mx_cxd, 1_jd, drjcx, nc_jcx, dmkt_jcx, drjz, drjsz, drzt, int_ack}
  assign obs = {o_dryx, o_yx, o_drjd, o_jsz_cxd, o_mx_cxd, o_1_jd, o_drjcx,
                o_nc_jcx, o_dmkt_jcx, o_drjz, o_drjsz, o_drzt, o_int_ack};

  task automatic drive(input logic [9:0] v);
    {i_start, i_stop, i_ind, i_mref, i_int_req, i_int_en,
     i_dch_req, i_kt_req, i_kt_store, i_mem_rdy} = v;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task test_reset();
    i_rst = 1'b1;
    drive(ST | RDY);
    tick();
    tick();
    #1;
    checks++; if (obs !== 13'h0) $display("FAIL reset_strobes got %h want %h", obs, 13'h0); else passed++;
    checks++; if (o_zt !== 7'h00) $display("FAIL reset_zt got %h want %h", o_zt, 7'h00); else passed++;
    checks++; if (o_err !== 1'b0) $display("FAIL reset_err got %b want 0", o_err); else passed++;
    i_rst = 1'b0;
    drive(RDY);
    tick();
    #1;
    checks++; if (obs !== 13'h0) $display("FAIL idle_strobes got %h want %h", obs, 13'h0); else passed++;
    checks++; if (o_zt !== 7'h00) $display("FAIL idle_zt got %h want %h", o_zt, 7'h00); else passed++;
  endtask

  task test_fetch();
    logic [9:0]  iv [0:9];
    logic [12:0] eo [0:9];
    logic [6:0]  ez [0:9];
    iv = '{ST|RDY, RDY, ST|RDY, RDY, RDY, RDY, RDY, RDY, SP|RDY, RDY};
    eo = '{13'h1800, 13'h0E00, 13'h0800, 13'h0860, 13'h080E,
           13'h0E00, 13'h0800, 13'h0860, 13'h100E, 13'h0000};
    ez = '{7'h00, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h00, 7'h00};
    for (int c = 0; c < 10; c++) begin
      drive(iv[c]);
      #1;
      checks++; if (obs !== eo[c]) $display("FAIL fetch_obs c=%0d got %h want %h", c, obs, eo[c]); else passed++;
      checks++; if (o_zt !== ez[c]) $display("FAIL fetch_zt c=%0d got %h want %h", c, o_zt, ez[c]); else passed++;
      tick();
    end
  endtask

  task test_indirect();
    logic [9:0]  iv [0:17];
    logic [12:0] eo [0:17];
    logic [6:0]  ez [0:17];
    iv = '{ST|RDY, RDY, RDY, RDY, IND|RDY, RDY, RDY, RDY, MREF|RDY,
           RDY, RDY, RDY, RDY, RDY, RDY, RDY, SP|RDY, RDY};
    eo = '{13'h1800, 13'h0E00, 13'h0800, 13'h0860, 13'h080E,
           13'h0D00, 13'h0800, 13'h0860, 13'h0802,
           13'h0D00, 13'h0800, 13'h0860, 13'h0802,
           13'h0E00, 13'h0800, 13'h0860, 13'h100E, 13'h0000};
    ez = '{7'h00, 7'h01, 7'h01, 7'h01, 7'h02, 7'h02, 7'h02, 7'h02, 7'h04,
           7'h04, 7'h04, 7'h04, 7'h01, 7'h01, 7'h01, 7'h01, 7'h00, 7'h00};
    for (int c = 0; c < 18; c++) begin
      drive(iv[c]);
      #1;
      checks++; if (obs !== eo[c]) $display("FAIL indirect_obs c=%0d got %h want %h", c, obs, eo[c]); else passed++;
      checks++; if (o_zt !== ez[c]) $display("FAIL indirect_zt c=%0d got %h want %h", c, o_zt, ez[c]); else passed++;
      tick();
    end
  endtask

  task test_dch_steal();
    logic [9:0]  iv [0:21];
    logic [12:0] eo [0:21];
    logic [6:0]  ez [0:21];
    iv = '{ST|RDY, RDY, RDY, RDY, IND|RDY, RDY, RDY, RDY, IND|RDY, RDY, RDY,
           RDY, DCH|MREF|RDY, RDY, RDY, RDY, RDY, RDY, RDY, RDY, SP|RDY, RDY};
    eo = '{13'h1800, 13'h0E00, 13'h0800, 13'h0860, 13'h080E,
           13'h0D00, 13'h0800, 13'h0860, 13'h0802,
           13'h0D00, 13'h0800, 13'h0860, 13'h0802,
           13'h0D00, 13'h0800, 13'h0860, 13'h0802,
           13'h0D00, 13'h0800, 13'h0860, 13'h1002, 13'h0000};
    ez = '{7'h00, 7'h01, 7'h01, 7'h01, 7'h02, 7'h02, 7'h02, 7'h02, 7'h02,
           7'h02, 7'h02, 7'h02, 7'h10, 7'h10, 7'h10, 7'h10, 7'h04,
           7'h04, 7'h04, 7'h04, 7'h00, 7'h00};
    for (int c = 0; c < 22; c++) begin
      drive(iv[c]);
      #1;
      checks++; if (obs !== eo[c]) $display("FAIL dch_obs c=%0d got %h want %h", c, obs, eo[c]); else passed++;
      checks++; if (o_zt !== ez[c]) $display("FAIL dch_zt c=%0d got %h want %h", c, o_zt, ez[c]); else passed++;
      tick();
    end
  endtask

  task test_interrupt();
    logic [9:0]  iv [0:25];
    logic [12:0] eo [0:25];
    logic [6:0]  ez [0:25];
    iv = '{ST|RDY, RDY, RDY, RDY, MREF|RDY, RDY, RDY, RDY, IRQ|IEN|RDY,
           RDY, RDY, RDY, RDY, RDY, RDY, RDY, IRQ|RDY, RDY, RDY, RDY,
           IRQ|RDY, RDY, RDY, RDY, SP|IRQ|IEN|RDY, RDY};
    eo = '{13'h1800, 13'h0E00, 13'h0800, 13'h0860, 13'h080E,
           13'h0D00, 13'h0800, 13'h0860, 13'h0802,
           13'h0C80, 13'h0800, 13'h0860, 13'h0803,
           13'h0D00, 13'h0800, 13'h0860, 13'h0802,
           13'h0D00, 13'h0800, 13'h0860, 13'h0802,
           13'h0E00, 13'h0800, 13'h0860, 13'h100E, 13'h0000};
    ez = '{7'h00, 7'h01, 7'h01, 7'h01, 7'h04, 7'h04, 7'h04, 7'h04, 7'h08,
           7'h08, 7'h08, 7'h08, 7'h02, 7'h02, 7'h02, 7'h02, 7'h04,
           7'h04, 7'h04, 7'h04, 7'h01, 7'h01, 7'h01, 7'h01, 7'h00, 7'h00};
    for (int c = 0; c < 26; c++) begin
      drive(iv[c]);
      #1;
      checks++; if (obs !== eo[c]) $display("FAIL int_obs c=%0d got %h want %h", c, obs, eo[c]); else passed++;
      checks++; if (o_zt !== ez[c]) $display("FAIL int_zt c=%0d got %h want %h", c, o_zt, ez[c]); else passed++;
      tick();
    end
  endtask

  task test_console();
    logic [9:0]  iv [0:15];
    logic [12:0] eo [0:15];
    logic [6:0]  ez [0:15];
    iv = '{KTR|KTS|RDY, RDY, RDY, RDY, RDY, KTR|RDY, RDY, RDY, RDY, RDY,
           ST|KTR|RDY, RDY, RDY, RDY, SP|RDY, RDY};
    eo = '{13'h0000, 13'h0500, 13'h0000, 13'h0050, 13'h0002,
           13'h0000, 13'h0500, 13'h0000, 13'h0060, 13'h0002,
           13'h1800, 13'h0E00, 13'h0800, 13'h0860, 13'h100E, 13'h0000};
    ez = '{7'h00, 7'h40, 7'h40, 7'h40, 7'h00, 7'h00, 7'h20, 7'h20, 7'h20, 7'h00,
           7'h00, 7'h01, 7'h01, 7'h01, 7'h00, 7'h00};
    for (int c = 0; c < 16; c++) begin
      drive(iv[c]);
      #1;
      checks++; if (obs !== eo[c]) $display("FAIL console_obs c=%0d got %h want %h", c, obs, eo[c]); else passed++;
      checks++; if (o_zt !== ez[c]) $display("FAIL console_zt c=%0d got %h want %h", c, o_zt, ez[c]); else passed++;
      tick();
    end
  endtask

  task test_timeout();
    logic [12:0] want;
    drive(ST | RDY);
    tick();
    drive(RDY);
    #1;
    checks++; if (obs !== 13'h0E00) $display("FAIL tmo_t0 got %h want %h", obs, 13'h0E00); else passed++;
    tick();
    for (int k = 1; k <= TMO; k++) begin
      drive(10'h000);
      #1;
      want = (k == TMO) ? 13'h1000 : 13'h0800;
      checks++; if (obs !== want) $display("FAIL tmo_wait k=%0d got %h want %h", k, obs, want); else passed++;
      tick();
    end
    drive(RDY);
    #1;
    checks++; if (o_err !== 1'b1) $display("FAIL tmo_err got %b want 1", o_err); else passed++;
    checks++; if (o_zt !== 7'h00) $display("FAIL tmo_idle_zt got %h want %h", o_zt, 7'h00); else passed++;
    checks++; if (obs !== 13'h0) $display("FAIL tmo_idle_obs got %h want %h", obs, 13'h0); else passed++;

    // Slow but in-budget memory: T1 stretches, error stays sticky.
    drive(ST | RDY);
    tick();
    drive(RDY);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(k == 3 ? RDY : 10'h000);
      #1;
      checks++; if (obs !== 13'h0800) $display("FAIL slow_t1 k=%0d got %h want %h", k, obs, 13'h0800); else passed++;
      tick();
    end
    #1;
    checks++; if (obs !== 13'h0860) $display("FAIL slow_t2 got %h want %h", obs, 13'h0860); else passed++;
    tick();
    #1;
    checks++; if (obs !== 13'h080E) $display("FAIL slow_t3 got %h want %h", obs, 13'h080E); else passed++;
    tick();
    #1;
    checks++; if (o_err !== 1'b1) $display("FAIL err_sticky got %b want 1", o_err); else passed++;
    tick();
    drive(10'h000);
    tick();
    i_rst = 1'b1;
    #1;
    checks++; if (obs !== 13'h0) $display("FAIL rst_mid_obs got %h want %h", obs, 13'h0); else passed++;
    checks++; if (o_zt !== 7'h00) $display("FAIL rst_mid_zt got %h want %h", o_zt, 7'h00); else passed++;
    tick();
    i_rst = 1'b0;
    drive(RDY);
    #1;
    checks++; if (o_err !== 1'b0) $display("FAIL rst_err_clr got %b want 0", o_err); else passed++;
    checks++; if (o_zt !== 7'h00) $display("FAIL rst_idle_zt got %h want %h", o_zt, 7'h00); else passed++;
    tick();
    #1;
    checks++; if (obs !== 13'h0) $display("FAIL rst_idle_obs got %h want %h", obs, 13'h0); else passed++;
  endtask

  initial begin
    i_rst = 1'b1;
    drive(10'h000);
    test_reset();
    test_fetch();
    test_indirect();
    test_dch_steal();
    test_interrupt();
    test_console();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/zt_seq_ctrl.md
Name: zt_seq_ctrl

Overview:
- Major-cycle sequencer for the CPU state/register file: fetch, indirect, execute, interrupt, data-channel, console and console-store cycles.
- Generates the one-clock load strobes (address, rewrite, instruction, counter, run, state) and the source selects that feed that register file.
- Arbitrates data-channel, interrupt and console requests at major-cycle boundaries.
- Sits between the front panel/IO request logic and the register/state block.

Parameters:
- MEM_TMO, 255, max clocks spent waiting for i_mem_rdy in beat T1 before aborting.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  run key pulse
- i_stop  in  1  halt request (level)
- i_ind  in  1  indirect bit of current word (valid at T3)
- i_mref  in  1  instruction needs execute memory cycle (valid at T3 of fetch/indirect)
- i_int_req  in  1  interrupt request
- i_int_en  in  1  interrupt enable
- i_dch_req  in  1  data-channel request
- i_kt_req  in  1  console cycle request (honoured only when halted)
- i_kt_store  in  1  console request is deposit (1) or examine (0)
- i_mem_rdy  in  1  memory ready
- o_zt  out  7  one-hot state {KTCZ,KT,STD,ZD,ZX,JZ,QZ} driven to the i_1_*ZT inputs
- o_yx  out  1  run flag value (i_1_YX)
- o_dryx  out  1  run load strobe
- o_drzt  out  1  state load strobe
- o_drjd, o_drjcx, o_drjz, o_drjsz  out  1 each  register load strobes
- o_jsz_cxd, o_mx_cxd, o_1_jd  out  1 each  address source selects
- o_nc_jcx, o_dmkt_jcx  out  1 each  rewrite source selects
- o_int_ack  out  1  one-clock interrupt acknowledge
- o_err  out  1  sticky memory-timeout flag

Behaviour:
- Reset:
  - state IDLE; o_zt=0; beat=T0; saved-next=QZ.
  - All strobes, selects, o_yx, o_int_ack and o_err = 0.
  - Reset mid-cycle abandons the cycle immediately; no strobe is issued in the reset cycle.
- States: IDLE, QZ, JZ, ZX, ZD, STD, KT, KTCZ. o_zt is the registered one-hot of the current state; IDLE = 0.
- Beats inside every non-IDLE state, T0 to T3, one clock each except T1:
  - T0: o_drjd pulses. Source select valid in the same clock:
    - QZ: o_jsz_cxd
    - ZD: o_1_jd
    - all other states: o_mx_cxd
  - T1: hold until i_mem_rdy=1. A wait counter increments each clock. If it reaches MEM_TMO: set o_err, drop o_yx via an o_dryx pulse, go to IDLE.
  - T2: o_drjcx pulses with o_nc_jcx. In KTCZ, o_dmkt_jcx is selected instead.
  - T3:
    - QZ only: o_drjz and o_drjsz pulse.
    - All states: o_drzt pulses, with o_zt presenting the NEXT state one-hot in that clock. The state register updates on the same edge.
- Next-state rules, evaluated at T3:
  - QZ: i_ind gives JZ; else i_mref gives ZX; else boundary arbitration.
  - JZ: i_ind gives JZ (chained); else ZX.
  - ZX: boundary arbitration.
  - ZD: JZ, with o_int_ack pulsing in ZD's T3.
  - STD: restore saved-next.
  - KT, KTCZ: IDLE.
- Boundary arbitration, priority order:
  1. i_stop: IDLE, with o_dryx and o_yx=0.
  2. i_dch_req: STD.
  3. i_int_req & i_int_en: ZD.
  4. Otherwise QZ.
- Data-channel steal at non-instruction boundaries: at T3 of QZ or JZ with i_dch_req=1, the computed next state is stored in saved-next and STD is entered instead.
- IDLE:
  - i_start: o_dryx with o_yx=1 in the same clock, then QZ T0 next clock.
  - Else i_kt_req: KTCZ if i_kt_store, else KT. o_yx stays 0.
  - i_start has priority over i_kt_req when both are asserted.
  - i_start while running is ignored.
- Strobes are exactly one clock wide and never overlap a reset cycle.
- o_err clears only on reset.

Decomposition:
- Shared package zt_pkg holds:
  - the state enum
  - the one-hot bit positions QZ..KTCZ, with QZ at bit 0
  - the beat enum T0..T3
- One sub-module, zt_beat_timer: beat counter plus T1 wait/timeout counter. Outputs are the beat and timeout signals.

Test Plan:
- Reset, then i_start pulse with i_mem_rdy=1, i_ind=0, i_mref=0 → o_dryx with o_yx=1; QZ cycle strobes at T0, T2, T3; o_zt=0000001; a second QZ follows. Each QZ takes 4 clocks.
- Fetch with i_ind=1 at T3, then i_ind=0 and i_mref=1 → o_zt sequence QZ→JZ→ZX→QZ (01,02,04,01 hex), with o_drzt once per cycle.
- i_dch_req asserted during JZ, with i_mref pending → JZ→STD→ZX. Saved-next restored; no o_drjz during STD.
- i_int_req=1, i_int_en=1 at ZX T3 → ZD with o_1_jd at T0; o_int_ack at ZD T3; next state JZ.
- Halted, i_kt_req=1 with i_kt_store=1 → KTCZ; o_dmkt_jcx at T2; return to IDLE with o_zt=0 and o_yx=0.
- i_mem_rdy held 0 for MEM_TMO clocks in QZ → o_err=1, IDLE, o_dryx pulse with o_yx=0. Reset in mid-wait clears o_err and returns to IDLE.
